// File: rtl/fifo_level.sv
// Parametrised synchronous FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
// Define FIFO_FWFT_EN to build a first-word-fall-through variant.
module fifo_level #(
    parameter int ABITS    = 4,
    parameter int DBITS    = 8,
    parameter int AF_LEVEL = (1 << ABITS) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic             rd,
    input  logic [DBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [ABITS:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ABITS;
    localparam logic [ABITS:0] FULL_CNT = DEPTH[ABITS:0];
    localparam logic [ABITS:0] AF_CNT   = AF_LEVEL[ABITS:0];
    localparam logic [ABITS:0] AE_CNT   = AE_LEVEL[ABITS:0];

    logic [DBITS-1:0] mem [DEPTH];
    logic [ABITS-1:0] wr_ptr;
    logic [ABITS-1:0] rd_ptr;
    logic [ABITS:0]   cnt;
    logic             ovf_q;
    logic             udf_q;

    logic rd_acc;
    logic wr_acc;
    logic bypass;
    logic wr_drop;
    logic rd_drop;

    // Status is decoded from registered count only.
    always_comb begin
        empty        = (cnt == '0);
        full         = (cnt == FULL_CNT);
        almost_empty = (cnt <= AE_CNT);
        almost_full  = (cnt >= AF_CNT);
        count        = cnt;
        overflow     = ovf_q;
        underflow    = udf_q;
    end

    always_comb begin
        rd_acc = rd & ~empty;
`ifdef FIFO_FWFT_EN
        bypass = 1'b0;
`else
        bypass = wr & rd & empty;
`endif
        // A read on a full FIFO frees the slot the write lands in.
        wr_acc  = wr & (~full | rd_acc) & ~bypass;
        wr_drop = wr & full & ~rd;
        rd_drop = rd & empty & ~bypass;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (wr_drop)
                ovf_q <= 1'b1;
            if (rd_drop)
                udf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && wr_acc)
            mem[wr_ptr] <= din;
    end

`ifdef FIFO_FWFT_EN
    always_comb begin
        dout = empty ? '0 : mem[rd_ptr];
    end
`else
    logic [DBITS-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dout_q <= '0;
        else if (clr)
            dout_q <= '0;
        else if (bypass)
            dout_q <= din;
        else if (rd_acc)
            dout_q <= mem[rd_ptr];
    end

    always_comb begin
        dout = dout_q;
    end
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level (ABITS=2, DBITS=8, AF=3, AE=1); expected values
// are hand-computed for both the registered and the FWFT build.
module tb_fifo_level;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    fifo_level #(
        .ABITS   (2),
        .DBITS   (8),
        .AF_LEVEL(3),
        .AE_LEVEL(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .wr          (wr),
        .rd          (rd),
        .din         (din),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       c;
        logic       w;
        logic       r;
        logic [7:0] d;
        logic [2:0] n;
        logic       o;
        logic       u;
        logic [7:0] dreg;
        logic [7:0] dfw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic c, input logic w, input logic r,
                               input logic [7:0] d, input logic [2:0] n,
                               input logic o, input logic u,
                               input logic [7:0] dreg, input logic [7:0] dfw);
        vec_t t;
        t.c = c; t.w = w; t.r = r; t.d = d; t.n = n;
        t.o = o; t.u = u; t.dreg = dreg; t.dfw = dfw;
        return t;
    endfunction

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: actual=%0h expected=%0h", nm, fld, act, exp);
        end
    endtask

    task automatic check(input string nm, input logic [2:0] n, input logic o,
                         input logic u, input logic [7:0] dreg,
                         input logic [7:0] dfw);
        logic [7:0] ed;
`ifdef FIFO_FWFT_EN
        ed = dfw;
`else
        ed = dreg;
`endif
        cmp(nm, "count",        32'(count),        32'(n));
        cmp(nm, "empty",        32'(empty),        32'(n == 3'd0));
        cmp(nm, "full",         32'(full),         32'(n == 3'd4));
        cmp(nm, "almost_empty", 32'(almost_empty), 32'(n <= 3'd1));
        cmp(nm, "almost_full",  32'(almost_full),  32'(n >= 3'd3));
        cmp(nm, "overflow",     32'(overflow),     32'(o));
        cmp(nm, "underflow",    32'(underflow),    32'(u));
        cmp(nm, "dout",         32'(dout),         32'(ed));
    endtask

    task automatic step(input logic c, input logic w, input logic r,
                        input logic [7:0] d);
        clr = c; wr = w; rd = r; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                c  w  r  din    n  o  u  dreg   dfw
        tbl.push_back(v(0, 1, 0, 8'h11, 1, 0, 0, 8'h00, 8'h11));
        tbl.push_back(v(0, 1, 0, 8'h22, 2, 0, 0, 8'h00, 8'h11));
        tbl.push_back(v(0, 1, 0, 8'h33, 3, 0, 0, 8'h00, 8'h11));
        tbl.push_back(v(0, 1, 0, 8'h44, 4, 0, 0, 8'h00, 8'h11));
        tbl.push_back(v(0, 1, 0, 8'h55, 4, 1, 0, 8'h00, 8'h11));
        tbl.push_back(v(0, 0, 1, 8'h00, 3, 1, 0, 8'h11, 8'h22));
        tbl.push_back(v(0, 0, 1, 8'h00, 2, 1, 0, 8'h22, 8'h33));
        tbl.push_back(v(0, 0, 1, 8'h00, 1, 1, 0, 8'h33, 8'h44));
        tbl.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 8'h44, 8'h00));
        tbl.push_back(v(0, 0, 1, 8'h00, 0, 1, 1, 8'h44, 8'h00));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00));
        tbl.push_back(v(0, 1, 0, 8'hA0, 1, 0, 0, 8'h00, 8'hA0));
        tbl.push_back(v(0, 1, 0, 8'hA1, 2, 0, 0, 8'h00, 8'hA0));
        tbl.push_back(v(0, 1, 0, 8'hA2, 3, 0, 0, 8'h00, 8'hA0));
        tbl.push_back(v(0, 1, 0, 8'hA3, 4, 0, 0, 8'h00, 8'hA0));
        tbl.push_back(v(0, 1, 1, 8'hB0, 4, 0, 0, 8'hA0, 8'hA1));
        tbl.push_back(v(0, 0, 1, 8'h00, 3, 0, 0, 8'hA1, 8'hA2));
        tbl.push_back(v(0, 0, 1, 8'h00, 2, 0, 0, 8'hA2, 8'hA3));
        tbl.push_back(v(0, 0, 1, 8'h00, 1, 0, 0, 8'hA3, 8'hB0));
        tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 8'hB0, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 8'hB0, 8'h00));

        // Reset held with a write pending
        rst = 1'b0; clr = 1'b0; wr = 1'b1; rd = 1'b0; din = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1; wr = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
            check($sformatf("vec%0d", i), tbl[i].n, tbl[i].o, tbl[i].u,
                  tbl[i].dreg, tbl[i].dfw);
        end

        // Simultaneous write and read on an empty FIFO
        step(0, 1, 1, 8'h5A);
`ifdef FIFO_FWFT_EN
        check("bypass", 1, 0, 1, 8'h5A, 8'h5A);
        step(0, 0, 0, 8'h00);
        check("bypass_hold", 1, 0, 1, 8'h5A, 8'h5A);
`else
        check("bypass", 0, 0, 0, 8'h5A, 8'h5A);
        step(0, 0, 0, 8'h00);
        check("bypass_hold", 0, 0, 0, 8'h5A, 8'h5A);
`endif

        // Flush with overflow pending and a concurrent write
        step(1, 0, 0, 8'h00);
        check("clr0", 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'hC1); check("fc1", 1, 0, 0, 8'h00, 8'hC1);
        step(0, 1, 0, 8'hC2); check("fc2", 2, 0, 0, 8'h00, 8'hC1);
        step(0, 1, 0, 8'hC3); check("fc3", 3, 0, 0, 8'h00, 8'hC1);
        step(0, 1, 0, 8'hC4); check("fc4", 4, 0, 0, 8'h00, 8'hC1);
        step(0, 1, 0, 8'hC5); check("fc5", 4, 1, 0, 8'h00, 8'hC1);
        step(0, 0, 1, 8'h00); check("frd", 3, 1, 0, 8'hC1, 8'hC2);
        step(1, 1, 0, 8'h77); check("flush", 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00); check("flush_idle", 0, 0, 0, 8'h00, 8'h00);

        // Async reset in the middle of a write burst
        step(0, 0, 1, 8'h00); check("udf_set", 0, 0, 1, 8'h00, 8'h00);
        step(0, 1, 0, 8'hD1); check("burst1", 1, 0, 1, 8'h00, 8'hD1);
        step(0, 1, 0, 8'hD2); check("burst2", 2, 0, 1, 8'h00, 8'hD1);
        din = 8'hD3;
        #2 rst = 1'b0;
        #1 check("async_rst", 0, 0, 0, 8'h00, 8'h00);
        #1 rst = 1'b1;
        wr = 1'b1; din = 8'hE1;
        @(posedge clk);
        #1 check("post_rst_wr", 1, 0, 0, 8'h00, 8'hE1);
        step(0, 0, 1, 8'h00);
        check("post_rst_rd", 0, 0, 0, 8'hE1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
